// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_redirect_unit
//  Purpose  : Instruction-fetch stage. Issues one memory request at a time,
//             fills the IF/ID register, holds a fetched word across load-use
//             stalls and applies branch/JAL/JALR redirects.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_Mux,
  input  logic [1:0]  target_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic [31:0] jal_target,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misalign_err
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;   // address of the abandoned request
  logic [31:0] hold_pc_q, hold_pc_d;         // one-entry stall buffer
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        misalign_q, misalign_d;
  logic        run_q;                         // reset-release delay flop

  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] redirect_pc;
  logic        unused_lsbs;

  // Redirect decode: select source, JALR clears bit0, PC always word aligned.
  always_comb begin
    raw_target = branch_target;
    case (target_sel)
      2'b00:   raw_target = branch_target;
      2'b01:   raw_target = {jalr_target[31:1], 1'b0};
      2'b10:   raw_target = jal_target;
      default: raw_target = branch_target;
    endcase
  end

  assign redirect    = PC_Mux && (target_sel != 2'b11);
  assign redirect_pc = {raw_target[31:2], 2'b00};
  // Bit 0 of every target never reaches the word-aligned PC.
  assign unused_lsbs = ^{branch_target[0], jal_target[0], raw_target[0]};

  // Memory interface: DRAIN keeps presenting the old address until it retires.
  assign imem_req     = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr    = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_valid  = if_id_valid_q;
  assign misalign_err = misalign_q;

  // Next-state, PC and IF/ID update logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_addr_d  = drain_addr_q;
    hold_pc_d     = hold_pc_q;
    hold_instr_d  = hold_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    misalign_d    = 1'b0;

    // Without a stall the decode stage consumes IF/ID; it becomes a bubble
    // unless a new word is loaded below.
    if (!stall) begin
      if_id_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (run_q) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          if (!imem_ready) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (imem_ready) begin
          if (stall) begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end else begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
          end
        end
      end
      DRAIN: begin
        if (imem_ready) begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = REQ;
        end else if (!stall) begin
          if_id_pc_d    = hold_pc_q;
          if_id_instr_d = hold_instr_q;
          if_id_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          state_d       = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect beats stalls and any response arriving this cycle.
    if (redirect) begin
      pc_d          = redirect_pc;
      misalign_d    = raw_target[1];
      if_id_valid_d = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      drain_addr_q  <= RESET_PC;
      hold_pc_q     <= 32'd0;
      hold_instr_q  <= NOP_INSTR;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_addr_q  <= drain_addr_d;
      hold_pc_q     <= hold_pc_d;
      hold_instr_q  <= hold_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      misalign_q    <= misalign_d;
      run_q         <= 1'b1;
    end
  end

endmodule
`default_nettype wire
